// File: rtl/regfile_bist.sv
// rtl/regfile_bist.sv - register file built-in self test
// Writes a seeded pattern, reads back in pairs, optionally repeats with inverted data.
module regfile_bist #(
  parameter bit INV_PASS = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        WEN,
  output logic [4:0]  wsel,
  output logic [31:0] wdat,
  output logic [4:0]  rsel1,
  output logic [4:0]  rsel2,
  input  logic [31:0] rdat1,
  input  logic [31:0] rdat2,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [6:0]  err_count,
  output logic [4:0]  fail_reg
);

  typedef enum logic [2:0] {IDLE, WR, RD, WR_INV, RD_INV, FIN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] seed_q;
  logic        rd_active;
  logic        inv;
  logic [31:0] exp1, exp2;
  logic        mm1, mm2;
  logic [6:0]  err_next;

  function automatic logic [31:0] pattern(input logic [31:0] s, input logic [4:0] i);
    return s + ({27'd0, i} * 32'h0808_0808);
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    WEN       = 1'b0;
    wsel      = 5'd0;
    wdat      = 32'd0;
    rsel1     = 5'd0;
    rsel2     = 5'd0;
    rd_active = 1'b0;
    inv       = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WR;
          cnt_d   = 5'd0;
        end
      end
      WR, WR_INV: begin
        WEN   = 1'b1;
        wsel  = cnt_q;
        wdat  = (state_q == WR_INV) ? ~pattern(seed_q, cnt_q) : pattern(seed_q, cnt_q);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = (state_q == WR) ? RD : RD_INV;
          cnt_d   = 5'd0;
        end
      end
      RD, RD_INV: begin
        rsel1     = {cnt_q[3:0], 1'b0};
        rsel2     = {cnt_q[3:0], 1'b1};
        rd_active = 1'b1;
        inv       = (state_q == RD_INV);
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = (state_q == RD && INV_PASS) ? WR_INV : FIN;
          cnt_d   = 5'd0;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register 0 is hardwired zero, so it never holds the written pattern.
  always_comb begin
    exp1     = (rsel1 == 5'd0) ? 32'd0 :
               (inv ? ~pattern(seed_q, rsel1) : pattern(seed_q, rsel1));
    exp2     = inv ? ~pattern(seed_q, rsel2) : pattern(seed_q, rsel2);
    mm1      = rd_active && (rdat1 != exp1);
    mm2      = rd_active && (rdat2 != exp2);
    err_next = err_count + {6'd0, mm1} + {6'd0, mm2};
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      seed_q    <= 32'd0;
      err_count <= 7'd0;
      fail_reg  <= 5'd0;
      pass      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && start) begin
        seed_q    <= seed;
        err_count <= 7'd0;
        fail_reg  <= 5'd0;
        pass      <= 1'b0;
      end else if (rd_active) begin
        err_count <= err_next;
        // err_count cannot wrap, so zero means no mismatch seen yet this test
        if (err_count == 7'd0 && (mm1 || mm2))
          fail_reg <= mm1 ? rsel1 : rsel2;
        if (state_d == FIN)
          pass <= (err_next == 7'd0);
      end
    end
  end

endmodule

// File: tb/tb_regfile_bist.sv
// tb/tb_regfile_bist.sv - self-checking bench for regfile_bist
module tb_regfile_bist;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic nRST;

  logic        start1, wen1, busy1, done1, pass1;
  logic [31:0] seed1, wdat1, rdat1a, rdat2a;
  logic [4:0]  wsel1, rsel1a, rsel2a, fail1;
  logic [6:0]  err1;

  logic        start0, wen0, busy0, done0, pass0;
  logic [31:0] seed0, wdat0, rdat10, rdat20;
  logic [4:0]  wsel0, rsel10, rsel20, fail0;
  logic [6:0]  err0;

  regfile_bist #(.INV_PASS(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .start(start1), .seed(seed1),
    .WEN(wen1), .wsel(wsel1), .wdat(wdat1), .rsel1(rsel1a), .rsel2(rsel2a),
    .rdat1(rdat1a), .rdat2(rdat2a), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_reg(fail1)
  );

  regfile_bist #(.INV_PASS(1'b0)) dut0 (
    .CLK(CLK), .nRST(nRST), .start(start0), .seed(seed0),
    .WEN(wen0), .wsel(wsel0), .wdat(wdat0), .rsel1(rsel10), .rsel2(rsel20),
    .rdat1(rdat10), .rdat2(rdat20), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_reg(fail0)
  );

  // Behavioural register files; the one behind dut can carry injected faults.
  logic [31:0] rf1 [32];
  logic [31:0] rf0 [32];
  logic        st_en, st_val, dead_en;
  int          st_reg, st_bit;

  always @(posedge CLK) begin
    if (wen1) rf1[wsel1] <= wdat1;
    if (wen0) rf0[wsel0] <= wdat0;
  end

  function automatic logic [31:0] fault_val(input int idx, input logic [31:0] stored);
    logic [31:0] v;
    if (idx == 0) return 32'd0;
    v = stored;
    if (dead_en && (idx == 4 || idx == 5)) v = 32'hDEAD_BEEF;
    if (st_en && idx == st_reg) v[st_bit] = st_val;
    return v;
  endfunction

  always_comb begin
    rdat1a = (rsel1a == 5'd0) ? 32'd0 : rf1[rsel1a];
    rdat2a = (rsel2a == 5'd0) ? 32'd0 : rf1[rsel2a];
    if (dead_en && (rsel1a == 5'd4 || rsel1a == 5'd5)) rdat1a = 32'hDEAD_BEEF;
    if (dead_en && (rsel2a == 5'd4 || rsel2a == 5'd5)) rdat2a = 32'hDEAD_BEEF;
    if (st_en && rsel1a != 5'd0 && int'(rsel1a) == st_reg) rdat1a[st_bit] = st_val;
    if (st_en && int'(rsel2a) == st_reg) rdat2a[st_bit] = st_val;
  end

  assign rdat10 = (rsel10 == 5'd0) ? 32'd0 : rf0[rsel10];
  assign rdat20 = (rsel20 == 5'd0) ? 32'd0 : rf0[rsel20];

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] s, input int i);
    return s + 32'(i) * 32'h0808_0808;
  endfunction

  // Expected outcome from first principles: every written value read back through the fault model.
  task automatic model(input logic [31:0] s, input int passes, output int exp_err, output int exp_fail);
    logic [31:0] w, e;
    exp_err  = 0;
    exp_fail = 0;
    for (int p = 0; p < passes; p++)
      for (int idx = 0; idx < 32; idx++) begin
        w = (p == 1) ? ~pat(s, idx) : pat(s, idx);
        e = (idx == 0) ? 32'd0 : w;
        if (fault_val(idx, w) != e) begin
          if (exp_err == 0) exp_fail = idx;
          exp_err++;
        end
      end
  endtask

  logic [31:0] wdat3;
  logic        wdat3_seen, k2_seen, k2_pend;
  logic [6:0]  k2_before, k2_after;

  task automatic run1(input logic [31:0] s, output int cycles, output int ndone);
    cycles = 0; ndone = 0; wdat3_seen = 0; k2_seen = 0; k2_pend = 0;
    @(negedge CLK);
    seed1 = s; start1 = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge CLK);
      start1 = 1'b0;
      if (busy1) cycles++;
      if (wen1 && wsel1 == 5'd3 && !wdat3_seen) begin wdat3 = wdat1; wdat3_seen = 1; end
      if (k2_pend) begin k2_after = err1; k2_pend = 0; end
      if (!k2_seen && rsel1a == 5'd4) begin k2_before = err1; k2_seen = 1; k2_pend = 1; end
      if (done1) begin ndone = 1; break; end
    end
  endtask

  task automatic count0(output int cycles, output int ndone);
    cycles = 0; ndone = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK);
      if (busy0) cycles++;
      if (done0) begin ndone = 1; break; end
    end
  endtask

  typedef struct {
    logic [31:0] seed;
    int          fault;
    logic        exp_pass;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [4];
  int   cyc, nd, ee, ef, dcnt;

  initial begin
    vecs[0] = '{32'h0000_0000, 0, 1'b1, 97};
    vecs[1] = '{32'h0000_0000, 1, 1'b0, 97};
    vecs[2] = '{32'h0000_0000, 2, 1'b0, 97};
    vecs[3] = '{32'h1234_5678, 0, 1'b1, 97};
    for (int i = 0; i < 32; i++) begin rf1[i] = 32'd0; rf0[i] = 32'd0; end
    st_en = 0; st_val = 0; dead_en = 0; st_reg = 0; st_bit = 0;
    nRST = 1'b0; start1 = 0; start0 = 0; seed1 = 0; seed0 = 0;
    repeat (2) @(negedge CLK);
    chk("reset_outputs",
        {busy1, done1, pass1, err1, fail1, wen1, wsel1, wdat1, rsel1a, rsel2a}, 0);
    nRST = 1'b1;

    for (int v = 0; v < 4; v++) begin
      st_en = (vecs[v].fault == 1); st_reg = 7; st_bit = 0; st_val = 1'b1;
      dead_en = (vecs[v].fault == 2);
      run1(vecs[v].seed, cyc, nd);
      model(vecs[v].seed, 2, ee, ef);
      chk($sformatf("v%0d_done", v), nd, 1);
      chk($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cycles);
      chk($sformatf("v%0d_pass", v), pass1, vecs[v].exp_pass);
      chk($sformatf("v%0d_err", v), err1, ee);
      if (ee != 0) chk($sformatf("v%0d_fail_reg", v), fail1, ef);
      if (vecs[v].seed == 32'd0 && vecs[v].fault == 0) chk("wdat_reg3", wdat3, 32'h1818_1818);
      if (vecs[v].fault == 2) begin
        chk("k2_err_before", k2_before, 0);
        chk("k2_err_after", k2_after, 2);
      end
      @(negedge CLK);
      chk($sformatf("v%0d_idle_after", v), {busy1, done1}, 0);
      chk($sformatf("v%0d_pass_held", v), pass1, vecs[v].exp_pass);
    end

    for (int r = 0; r < 6; r++) begin
      logic [31:0] s;
      s = $urandom;
      st_en = 1'($urandom_range(0, 1)); st_reg = $urandom_range(1, 31);
      st_bit = $urandom_range(0, 31); st_val = 1'($urandom_range(0, 1));
      dead_en = 1'($urandom_range(0, 1));
      run1(s, cyc, nd);
      model(s, 2, ee, ef);
      chk($sformatf("r%0d_cycles", r), cyc, 97);
      chk($sformatf("r%0d_err", r), err1, ee);
      chk($sformatf("r%0d_pass", r), pass1, (ee == 0));
      if (ee != 0) chk($sformatf("r%0d_fail_reg", r), fail1, ef);
    end

    st_en = 0; dead_en = 0; cyc = 0; dcnt = 0;
    @(negedge CLK);
    seed1 = 32'hA5A5_0001; start1 = 1'b1;
    for (int t = 0; t < 100 && cyc < 40; t++) begin
      @(negedge CLK);
      start1 = 1'b0;
      if (busy1) cyc++;
    end
    chk("reset_reached_cycle40", cyc, 40);
    nRST = 1'b0;
    #1;
    chk("midtest_reset_outputs",
        {busy1, done1, pass1, err1, fail1, wen1, wsel1, wdat1, rsel1a, rsel2a}, 0);
    for (int t = 0; t < 8; t++) begin
      @(negedge CLK);
      if (t == 2) nRST = 1'b1;
      if (done1) dcnt++;
    end
    chk("no_done_after_reset", dcnt, 0);
    chk("idle_after_reset", busy1, 0);
    run1(32'hC0FF_EE00, cyc, nd);
    chk("post_reset_cycles", cyc, 97);
    chk("post_reset_pass", pass1, 1);

    @(negedge CLK);
    seed0 = 32'h0F0F_1234; start0 = 1'b1;
    count0(cyc, nd);
    chk("held_first_done", nd, 1);
    chk("held_first_cycles", cyc, 49);
    chk("held_first_pass", pass0, 1);
    @(negedge CLK);
    chk("held_idle_gap", busy0, 0);
    count0(cyc, nd);
    chk("held_second_cycles", cyc, 49);
    chk("held_second_err", err0, 0);
    start0 = 1'b0;
    dcnt = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge CLK);
      if (busy0 || done0) dcnt++;
    end
    chk("held_stops_after_release", dcnt, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
